// File: rtl/tl_mem_responder.sv
// Single-transaction TileLink memory responder: accepts acquires/releases, stores
// 4-beat lines, and answers with a grant after a fixed latency.
module tl_mem_responder #(
  parameter int LATENCY     = 4,
  parameter int BLOCKS_LOG2 = 8
) (
  input  logic         clk,
  input  logic         reset,
  output logic         io_mem_acquire_ready,
  input  logic         io_mem_acquire_valid,
  input  logic [25:0]  io_mem_acquire_bits_addr_block,
  input  logic [1:0]   io_mem_acquire_bits_client_xact_id,
  input  logic [1:0]   io_mem_acquire_bits_addr_beat,
  input  logic         io_mem_acquire_bits_is_builtin_type,
  input  logic [2:0]   io_mem_acquire_bits_a_type,
  input  logic [16:0]  io_mem_acquire_bits_union,
  input  logic [127:0] io_mem_acquire_bits_data,
  input  logic         io_mem_grant_ready,
  output logic         io_mem_grant_valid,
  output logic [1:0]   io_mem_grant_bits_addr_beat,
  output logic [1:0]   io_mem_grant_bits_client_xact_id,
  output logic [3:0]   io_mem_grant_bits_manager_xact_id,
  output logic         io_mem_grant_bits_is_builtin_type,
  output logic [3:0]   io_mem_grant_bits_g_type,
  output logic [127:0] io_mem_grant_bits_data,
  input  logic         io_mem_probe_ready,
  output logic         io_mem_probe_valid,
  output logic         io_mem_release_ready,
  input  logic         io_mem_release_valid,
  input  logic [1:0]   io_mem_release_bits_addr_beat,
  input  logic [25:0]  io_mem_release_bits_addr_block,
  input  logic [1:0]   io_mem_release_bits_client_xact_id,
  input  logic         io_mem_release_bits_voluntary,
  input  logic [2:0]   io_mem_release_bits_r_type,
  input  logic [127:0] io_mem_release_bits_data
);

  // Handshakes: a beat transfers on the rising clk edge where valid && ready are both 1;
  // the sender holds valid and bits stable until that edge.

  localparam int AW = BLOCKS_LOG2 + 2;
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ_DATA,
    S_REL_DATA,
    S_WAIT,
    S_GRANT
  } state_t;

  state_t state_q, state_d;

  logic [3:0]             wait_q;
  logic [1:0]             beat_q;
  logic [1:0]             last_q;
  logic [1:0]             in_cnt_q;
  logic [BLOCKS_LOG2-1:0] blk_q;
  logic [1:0]             cid_q;
  logic [3:0]             mid_q;
  logic [3:0]             mid_cnt_q;
  logic                   builtin_q;
  logic [3:0]             gtype_q;
  logic                   read_q;
  logic                   vol_q;

  logic             acq_fire, rel_fire, accept_first;
  logic             acq_put, acq_read, rel_has_data;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [127:0]     mem_wdata;
  logic [127:0]     line_mem [2**AW];

  logic unused_bits;
  assign unused_bits = ^{io_mem_acquire_bits_union, io_mem_probe_ready,
                         io_mem_acquire_bits_addr_block[25:BLOCKS_LOG2],
                         io_mem_release_bits_addr_block[25:BLOCKS_LOG2]};

  // Readies are forced low while reset is held; release wins over acquire in IDLE.
  always_comb begin
    io_mem_acquire_ready = 1'b0;
    io_mem_release_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          io_mem_release_ready = 1'b1;
          io_mem_acquire_ready = !io_mem_release_valid;
        end
        S_ACQ_DATA: io_mem_acquire_ready = 1'b1;
        S_REL_DATA: io_mem_release_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign acq_fire     = io_mem_acquire_valid && io_mem_acquire_ready;
  assign rel_fire     = io_mem_release_valid && io_mem_release_ready;
  assign accept_first = (state_q == S_IDLE) && (acq_fire || rel_fire);
  assign acq_put      = io_mem_acquire_bits_is_builtin_type && (io_mem_acquire_bits_a_type == 3'd3);
  assign acq_read     = !io_mem_acquire_bits_is_builtin_type || (io_mem_acquire_bits_a_type == 3'd1);
  assign rel_has_data = io_mem_release_bits_r_type <= 3'd2;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rel_fire) begin
          if (rel_has_data)                       state_d = S_REL_DATA;
          else if (io_mem_release_bits_voluntary) state_d = S_WAIT;
          else                                    state_d = S_IDLE;
        end else if (acq_fire) begin
          state_d = acq_put ? S_ACQ_DATA : S_WAIT;
        end
      end
      S_ACQ_DATA: if (acq_fire && in_cnt_q == 2'd3) state_d = S_WAIT;
      S_REL_DATA: if (rel_fire && in_cnt_q == 2'd3) state_d = vol_q ? S_WAIT : S_IDLE;
      S_WAIT:     if (wait_q <= 4'd1) state_d = S_GRANT;
      S_GRANT:    if (io_mem_grant_ready && beat_q == last_q) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q    <= '0;
      beat_q    <= '0;
      last_q    <= '0;
      in_cnt_q  <= '0;
      blk_q     <= '0;
      cid_q     <= '0;
      mid_q     <= '0;
      mid_cnt_q <= '0;
      builtin_q <= 1'b0;
      gtype_q   <= '0;
      read_q    <= 1'b0;
      vol_q     <= 1'b0;
    end else begin
      if (accept_first) begin
        mid_q     <= mid_cnt_q;
        mid_cnt_q <= mid_cnt_q + 4'd1;
        in_cnt_q  <= 2'd1;
        beat_q    <= '0;
        if (rel_fire) begin
          cid_q     <= io_mem_release_bits_client_xact_id;
          blk_q     <= io_mem_release_bits_addr_block[BLOCKS_LOG2-1:0];
          vol_q     <= io_mem_release_bits_voluntary;
          builtin_q <= 1'b1;
          gtype_q   <= 4'd0;
          read_q    <= 1'b0;
          last_q    <= 2'd0;
        end else begin
          cid_q     <= io_mem_acquire_bits_client_xact_id;
          blk_q     <= io_mem_acquire_bits_addr_block[BLOCKS_LOG2-1:0];
          vol_q     <= 1'b0;
          builtin_q <= io_mem_acquire_bits_is_builtin_type;
          if (!io_mem_acquire_bits_is_builtin_type)
            gtype_q <= (io_mem_acquire_bits_a_type == 3'd1) ? 4'd1 : 4'd0;
          else
            gtype_q <= (io_mem_acquire_bits_a_type == 3'd1) ? 4'd5 : 4'd3;
          read_q    <= acq_read;
          last_q    <= acq_read ? 2'd3 : 2'd0;
        end
      end else if (acq_fire || rel_fire) begin
        in_cnt_q <= in_cnt_q + 2'd1;
      end

      if (state_q != S_WAIT && state_d == S_WAIT) wait_q <= LAT4;
      else if (state_q == S_WAIT)                 wait_q <= wait_q - 4'd1;

      if (state_q == S_GRANT && io_mem_grant_ready && beat_q != last_q)
        beat_q <= beat_q + 2'd1;
    end
  end

  // Storage is deliberately outside the reset domain so lines survive a reset.
  assign mem_we = (acq_fire && (state_q == S_ACQ_DATA || acq_put)) ||
                  (rel_fire && (state_q == S_REL_DATA || rel_has_data));
  assign mem_waddr = acq_fire
    ? {io_mem_acquire_bits_addr_block[BLOCKS_LOG2-1:0], io_mem_acquire_bits_addr_beat}
    : {io_mem_release_bits_addr_block[BLOCKS_LOG2-1:0], io_mem_release_bits_addr_beat};
  assign mem_wdata = acq_fire ? io_mem_acquire_bits_data : io_mem_release_bits_data;

  always_ff @(posedge clk) begin
    if (mem_we) line_mem[mem_waddr] <= mem_wdata;
  end

  // No writes can occur while a grant is pending, so reading the line live is
  // equivalent to capturing it on entry to GRANT.
  assign io_mem_grant_valid                = (state_q == S_GRANT);
  assign io_mem_grant_bits_addr_beat       = beat_q;
  assign io_mem_grant_bits_client_xact_id  = cid_q;
  assign io_mem_grant_bits_manager_xact_id = mid_q;
  assign io_mem_grant_bits_is_builtin_type = builtin_q;
  assign io_mem_grant_bits_g_type          = gtype_q;
  assign io_mem_grant_bits_data            = read_q ? line_mem[{blk_q, beat_q}] : '0;
  assign io_mem_probe_valid                = 1'b0;

endmodule

// File: tb/tb_tl_mem_responder.sv
// Self-checking bench for tl_mem_responder: directed scenarios plus randomized
// transactions checked against a line-level reference model.
module tb_tl_mem_responder;
  localparam int LAT = 4;
  localparam int GW  = 141;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         acquire_ready, acquire_valid = 1'b0;
  logic [25:0]  acquire_block = '0;
  logic [1:0]   acquire_cid = '0, acquire_beat = '0;
  logic         acquire_builtin = 1'b0;
  logic [2:0]   acquire_atype = '0;
  logic [16:0]  acquire_union = '0;
  logic [127:0] acquire_data = '0;
  logic         grant_ready = 1'b0, grant_valid;
  logic [1:0]   grant_beat, grant_cid;
  logic [3:0]   grant_mid, grant_gtype;
  logic         grant_builtin;
  logic [127:0] grant_data;
  logic         probe_ready = 1'b0, probe_valid;
  logic         release_ready, release_valid = 1'b0;
  logic [1:0]   release_beat = '0, release_cid = '0;
  logic [25:0]  release_block = '0;
  logic         release_vol = 1'b0;
  logic [2:0]   release_rtype = '0;
  logic [127:0] release_data = '0;

  tl_mem_responder #(.LATENCY(LAT), .BLOCKS_LOG2(8)) dut (
    .clk(clk), .reset(reset),
    .io_mem_acquire_ready(acquire_ready), .io_mem_acquire_valid(acquire_valid),
    .io_mem_acquire_bits_addr_block(acquire_block), .io_mem_acquire_bits_client_xact_id(acquire_cid),
    .io_mem_acquire_bits_addr_beat(acquire_beat), .io_mem_acquire_bits_is_builtin_type(acquire_builtin),
    .io_mem_acquire_bits_a_type(acquire_atype), .io_mem_acquire_bits_union(acquire_union),
    .io_mem_acquire_bits_data(acquire_data),
    .io_mem_grant_ready(grant_ready), .io_mem_grant_valid(grant_valid),
    .io_mem_grant_bits_addr_beat(grant_beat), .io_mem_grant_bits_client_xact_id(grant_cid),
    .io_mem_grant_bits_manager_xact_id(grant_mid), .io_mem_grant_bits_is_builtin_type(grant_builtin),
    .io_mem_grant_bits_g_type(grant_gtype), .io_mem_grant_bits_data(grant_data),
    .io_mem_probe_ready(probe_ready), .io_mem_probe_valid(probe_valid),
    .io_mem_release_ready(release_ready), .io_mem_release_valid(release_valid),
    .io_mem_release_bits_addr_beat(release_beat), .io_mem_release_bits_addr_block(release_block),
    .io_mem_release_bits_client_xact_id(release_cid), .io_mem_release_bits_voluntary(release_vol),
    .io_mem_release_bits_r_type(release_rtype), .io_mem_release_bits_data(release_data)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acq_fires = 0;
  int acc_cyc, first_cyc, held_bad;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (acquire_valid && acquire_ready) acq_fires <= acq_fires + 1;

  // Scoreboard: expected and observed grant beats as {beat, cid, mid, builtin, g_type, data}.
  logic [GW-1:0] exp_q[$];
  logic [GW-1:0] got_q[$];
  int            got_cyc[$];

  // Reference model: line store keyed by block*4+beat, and the expected manager id.
  logic [127:0] model_mem [int];
  logic [3:0]   exp_mid = '0;

  function automatic logic [GW-1:0] pack_g(logic [1:0] b, logic [1:0] cid, logic [3:0] mid,
                                           logic bi, logic [3:0] gt, logic [127:0] d);
    return {b, cid, mid, bi, gt, d};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] mread(int key);
    return model_mem.exists(key) ? model_mem[key] : 128'h0;
  endfunction

  task automatic model_acq(input logic [25:0] blk, input logic [1:0] cid, input logic bi,
                           input logic [2:0] at, input logic [3:0][127:0] line);
    int base;
    logic [3:0] mid;
    base = int'(blk[7:0]) * 4;
    mid = exp_mid;
    exp_mid = exp_mid + 4'd1;
    if (bi && at == 3'd3) begin
      for (int b = 0; b < 4; b++) model_mem[base + b] = line[b];
      exp_q.push_back(pack_g(2'd0, cid, mid, 1'b1, 4'd3, 128'h0));
    end else if (!bi || at == 3'd1) begin
      for (int b = 0; b < 4; b++)
        exp_q.push_back(pack_g(2'(b), cid, mid, bi, bi ? 4'd5 : ((at == 3'd1) ? 4'd1 : 4'd0),
                               mread(base + b)));
    end else begin
      exp_q.push_back(pack_g(2'd0, cid, mid, 1'b1, 4'd3, 128'h0));
    end
  endtask

  task automatic model_rel(input logic [25:0] blk, input logic [1:0] cid, input logic vol,
                           input logic [2:0] rt, input logic [3:0][127:0] line);
    logic [3:0] mid;
    mid = exp_mid;
    exp_mid = exp_mid + 4'd1;
    if (rt <= 3'd2)
      for (int b = 0; b < 4; b++) model_mem[int'(blk[7:0]) * 4 + b] = line[b];
    if (vol) exp_q.push_back(pack_g(2'd0, cid, mid, 1'b1, 4'd0, 128'h0));
  endtask

  task automatic send_acq(input logic [25:0] blk, input logic [1:0] cid, input logic [1:0] beat,
                          input logic bi, input logic [2:0] at, input logic [127:0] d);
    bit done = 0;
    acquire_block = blk; acquire_cid = cid; acquire_beat = beat;
    acquire_builtin = bi; acquire_atype = at; acquire_data = d;
    acquire_union = 17'($urandom);
    acquire_valid = 1'b1;
    for (int w = 0; w < 100 && !done; w++) begin
      @(negedge clk);
      if (acquire_ready) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        done = 1;
      end
    end
    acquire_valid = 1'b0;
    checks++;
    if (!done) begin failures++; $display("FAIL acq_accept timeout got=0 exp=1 blk=%h", blk); end
  endtask

  task automatic send_rel(input logic [25:0] blk, input logic [1:0] cid, input logic [1:0] beat,
                          input logic vol, input logic [2:0] rt, input logic [127:0] d);
    bit done = 0;
    release_block = blk; release_cid = cid; release_beat = beat;
    release_vol = vol; release_rtype = rt; release_data = d;
    release_valid = 1'b1;
    for (int w = 0; w < 100 && !done; w++) begin
      @(negedge clk);
      if (release_ready) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        done = 1;
      end
    end
    release_valid = 1'b0;
    checks++;
    if (!done) begin failures++; $display("FAIL rel_accept timeout got=0 exp=1 blk=%h", blk); end
  endtask

  task automatic send_put(input logic [25:0] blk, input logic [1:0] cid, input logic [3:0][127:0] line);
    for (int b = 0; b < 4; b++) send_acq(blk, cid, 2'(b), 1'b1, 3'd3, line[b]);
  endtask

  task automatic send_rel_line(input logic [25:0] blk, input logic [1:0] cid, input logic vol,
                               input logic [2:0] rt, input logic [3:0][127:0] line);
    for (int b = 0; b < 4; b++) send_rel(blk, cid, 2'(b), vol, rt, line[b]);
  endtask

  // Collects n grant handshakes; with stall set, grant_ready alternates 0/1 and any
  // change of a stalled beat's fields is counted in held_bad.
  task automatic recv_grants(input int n, input bit stall);
    logic [GW-1:0] cur, hold;
    bit have_hold = 0;
    int w = 0;
    got_q.delete(); got_cyc.delete();
    held_bad = 0; first_cyc = -1;
    grant_ready = !stall;
    while (got_q.size() < n && w < 200) begin
      @(negedge clk);
      if (grant_valid) begin
        cur = pack_g(grant_beat, grant_cid, grant_mid, grant_builtin, grant_gtype, grant_data);
        if (first_cyc < 0) first_cyc = cyc;
        if (have_hold && cur !== hold) held_bad++;
        if (grant_ready) begin
          got_q.push_back(cur); got_cyc.push_back(cyc); have_hold = 0;
        end else begin
          hold = cur; have_hold = 1;
        end
      end
      @(posedge clk); #1;
      w++;
      grant_ready = stall ? !grant_ready : 1'b1;
    end
    grant_ready = 1'b0;
  endtask

  task automatic do_reset();
    acquire_valid = 1'b0; release_valid = 1'b0; grant_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_mid = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (acquire_ready !== 1'b0 || release_ready !== 1'b0) begin
      failures++; $display("FAIL reset_readies got=%b%b exp=00", acquire_ready, release_ready);
    end
    checks++;
    if (grant_valid !== 1'b0 || probe_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valids got=%b%b exp=00", grant_valid, probe_valid);
    end
    checks++;
    if (pack_g(grant_beat, grant_cid, grant_mid, grant_builtin, grant_gtype, grant_data) !== '0) begin
      failures++; $display("FAIL reset_grant_bits got=%h exp=0",
                           pack_g(grant_beat, grant_cid, grant_mid, grant_builtin, grant_gtype, grant_data));
    end
    @(posedge clk); #1 reset = 1'b0;
    exp_mid = '0;
    @(negedge clk);
    checks++;
    if (acquire_ready !== 1'b1 || release_ready !== 1'b1) begin
      failures++; $display("FAIL idle_readies got=%b%b exp=11", acquire_ready, release_ready);
    end
    release_valid = 1'b1;
    #1;
    checks++;
    if (acquire_ready !== 1'b0) begin failures++; $display("FAIL idle_rel_priority got=%b exp=0", acquire_ready); end
    release_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_put_get();
    logic [3:0][127:0] line;
    line = {128'h44, 128'h33, 128'h22, 128'h11};
    exp_q.delete();
    model_acq(26'h10, 2'd1, 1'b1, 3'd3, line);
    send_put(26'h10, 2'd1, line);
    recv_grants(1, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL put_ack count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL put_ack beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (first_cyc - acc_cyc != LAT) begin failures++; $display("FAIL put_latency got=%0d exp=%0d", first_cyc - acc_cyc, LAT); end

    exp_q.delete();
    model_acq(26'h10, 2'd2, 1'b0, 3'd1, '0);
    send_acq(26'h10, 2'd2, 2'd0, 1'b0, 3'd1, 128'h0);
    recv_grants(4, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL read count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL read beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      checks++;
      if (got_cyc[i] != got_cyc[0] + i) begin failures++; $display("FAIL read_b2b beat%0d got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); end
    end
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0) begin failures++; $display("FAIL read_extra_beat got=%b exp=0", grant_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_release_priority();
    logic [3:0][127:0] line;
    logic [25:0] blk;
    int fires_before;
    for (int b = 0; b < 4; b++) line[b] = rand128();
    blk = {18'($urandom), 8'h20};
    fires_before = acq_fires;
    acquire_block = blk; acquire_cid = 2'd1; acquire_beat = 2'd0;
    acquire_builtin = 1'b0; acquire_atype = 3'd1; acquire_data = '0;
    acquire_valid = 1'b1;
    release_block = blk; release_cid = 2'd3; release_beat = 2'd0;
    release_vol = 1'b1; release_rtype = 3'd0; release_data = line[0];
    release_valid = 1'b1;
    #1;
    checks++;
    if (acquire_ready !== 1'b0 || release_ready !== 1'b1) begin
      failures++; $display("FAIL both_valid_readies got=%b%b exp=01", acquire_ready, release_ready);
    end
    exp_q.delete();
    model_rel(blk, 2'd3, 1'b1, 3'd0, line);
    send_rel_line(blk, 2'd3, 1'b1, 3'd0, line);
    acquire_valid = 1'b1;
    recv_grants(1, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rel_ack count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rel_ack beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (acq_fires != fires_before) begin failures++; $display("FAIL acq_held_off got=%0d exp=%0d", acq_fires, fires_before); end
    exp_q.delete();
    model_acq(blk, 2'd1, 1'b0, 3'd1, '0);
    send_acq(blk, 2'd1, 2'd0, 1'b0, 3'd1, 128'h0);
    recv_grants(4, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rel_then_read count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rel_then_read beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    logic [25:0] blk;
    blk = {18'($urandom), 8'h20};
    exp_q.delete();
    model_acq(blk, 2'd0, 1'b1, 3'd1, '0);
    send_acq(blk, 2'd0, 2'd0, 1'b1, 3'd1, 128'h0);
    recv_grants(4, 1'b1);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL stall count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (held_bad != 0) begin failures++; $display("FAIL stall_hold got=%0d exp=0", held_bad); end
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0) begin failures++; $display("FAIL stall_extra_beat got=%b exp=0", grant_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_xact_id();
    logic [2:0] at;
    logic [GW-1:0] g;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      do at = 3'($urandom_range(0, 7)); while (at == 3'd1 || at == 3'd3);
      exp_q.delete();
      model_acq(26'($urandom), 2'(i), 1'b1, at, '0);
      send_acq(26'($urandom), 2'(i), 2'd0, 1'b1, at, rand128());
      recv_grants(1, 1'b0);
      g = (got_q.size() > 0) ? got_q[0] : '1;
      checks++;
      if (g[136:133] !== 4'(i)) begin failures++; $display("FAIL mgr_id txn%0d got=%0d exp=%0d", i, g[136:133], 4'(i)); end
      checks++;
      if (g !== exp_q[0]) begin failures++; $display("FAIL ack txn%0d got=%h exp=%h", i, g, exp_q[0]); end
    end
  endtask

  task automatic test_reset_wait();
    int seen = 0;
    logic [25:0] blk;
    blk = {18'($urandom), 8'h10};
    send_acq(blk, 2'd3, 2'd0, 1'b0, 3'd0, 128'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || acquire_ready !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%b%b exp=00", grant_valid, acquire_ready);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_mid = '0;
    repeat (LAT + 6) begin
      @(negedge clk);
      if (grant_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL abandoned_grant got=%0d exp=0", seen); end
    @(posedge clk); #1;
    exp_q.delete();
    model_acq(blk, 2'd3, 1'b0, 3'd0, '0);
    send_acq(blk, 2'd3, 2'd0, 1'b0, 3'd0, 128'h0);
    recv_grants(4, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL retained count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL retained beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [3:0][127:0] line;
    logic [25:0] blk;
    logic [1:0]  cid;
    logic [2:0]  at;
    logic        vol;
    int kind, seen;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 4; b++) line[b] = rand128();
      blk = {18'($urandom), 8'(8'h40 + k)};
      exp_q.delete();
      model_acq(blk, 2'd0, 1'b1, 3'd3, line);
      send_put(blk, 2'd0, line);
      recv_grants(1, 1'b0);
    end
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      blk = {18'($urandom), 8'(8'h40 + $urandom_range(0, 3))};
      cid = 2'($urandom);
      vol = 1'($urandom);
      for (int b = 0; b < 4; b++) line[b] = rand128();
      exp_q.delete();
      case (kind)
        0: begin model_acq(blk, cid, 1'b1, 3'd3, line); send_put(blk, cid, line); end
        1: begin model_acq(blk, cid, 1'b1, 3'd1, '0); send_acq(blk, cid, 2'd0, 1'b1, 3'd1, 128'h0); end
        2: begin
          at = 3'($urandom);
          model_acq(blk, cid, 1'b0, at, '0); send_acq(blk, cid, 2'd0, 1'b0, at, 128'h0);
        end
        3: begin
          do at = 3'($urandom_range(0, 7)); while (at == 3'd1 || at == 3'd3);
          model_acq(blk, cid, 1'b1, at, '0); send_acq(blk, cid, 2'd0, 1'b1, at, rand128());
        end
        4: begin
          at = 3'($urandom_range(0, 2));
          model_rel(blk, cid, vol, at, line); send_rel_line(blk, cid, vol, at, line);
        end
        default: begin
          at = 3'($urandom_range(3, 7));
          model_rel(blk, cid, vol, at, line); send_rel(blk, cid, 2'd0, vol, at, line[0]);
        end
      endcase
      if (exp_q.size() == 0) begin
        seen = 0;
        repeat (LAT + 3) begin @(negedge clk); if (grant_valid) seen++; end
        @(posedge clk); #1;
        checks++;
        if (seen != 0) begin failures++; $display("FAIL rnd%0d unexpected_grant got=%0d exp=0", n, seen); end
      end else begin
        recv_grants(exp_q.size(), 1'($urandom));
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd%0d count got=%0d exp=%0d", n, got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d beat%0d got=%h exp=%h", n, i, got_q[i], exp_q[i]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_release_priority();
    test_stall();
    test_xact_id();
    test_reset_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
